// File: rtl/dmem_arbiter_pkg.sv
// Shared op codes, FSM state encoding and helpers for the data-memory arbiter.
package dmem_pkg;

  localparam logic [2:0] LW  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LHU = 3'd2;
  localparam logic [2:0] LB  = 3'd3;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] SB  = 3'd5;
  localparam logic [2:0] SH  = 3'd6;
  localparam logic [2:0] SW  = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  function automatic logic is_store(input logic [2:0] op);
    return op >= SB;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the port that did not win last is chosen.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (&req_i) gnt_o = last_i ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin data-memory arbiter with RMW bus lock and registered read return.
// Optional alignment checking is enabled by defining DMEM_ARB_ALIGN_CHK_EN.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic [2:0]    op0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          lock0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic [2:0]    op1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  input  logic          lock1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic [2:0]    mem_op,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          lock_err
`ifdef DMEM_ARB_ALIGN_CHK_EN
  ,
  output logic          align_err0,
  output logic          align_err1
`endif
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic            lock_err_q, lock_err_d;
  logic            rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DW-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [1:0]      eff_req, gnt;
  logic [2:0]      sel_op;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic            mis;

  // The non-owner is masked out while a lock is held.
  always_comb begin
    eff_req = {req1, req0};
    if (state_q == LOCK0) eff_req[1] = 1'b0;
    if (state_q == LOCK1) eff_req[0] = 1'b0;
  end

  rr_arb2 u_rr (
    .req_i  (eff_req),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  always_comb begin
    sel_op    = gnt[1] ? op1    : op0;
    sel_addr  = gnt[1] ? addr1  : addr0;
    sel_wdata = gnt[1] ? wdata1 : wdata0;
    mis       = 1'b0;
`ifdef DMEM_ARB_ALIGN_CHK_EN
    case (sel_op)
      LW, SW:      mis = (sel_addr[1:0] != 2'b00);
      LH, LHU, SH: mis = sel_addr[0];
      default:     mis = 1'b0;
    endcase
`endif
    mem_op    = LW;
    mem_addr  = '0;
    mem_wdata = '0;
    if (|gnt) begin
      // A misaligned access is degraded to a load so memory is never written.
      mem_op    = mis ? LW : sel_op;
      mem_addr  = sel_addr;
      mem_wdata = sel_wdata;
    end
  end

  always_comb begin
    rvalid0_d = gnt[0] & ~is_store(op0);
    rvalid1_d = gnt[1] & ~is_store(op1);
    rdata0_d  = rvalid0_d ? (mis ? '0 : mem_rdata) : rdata0_q;
    rdata1_d  = rvalid1_d ? (mis ? '0 : mem_rdata) : rdata1_q;
  end

  // Lock FSM: counter runs every locked cycle so the other port waits at most LOCK_MAX.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cnt_inc    = cnt_q + 1'b1;
    last_d     = (|gnt) ? gnt[1] : last_q;
    lock_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt[0] && lock0) begin
          state_d = LOCK0;
          cnt_d   = CW'(1);
        end else if (gnt[1] && lock1) begin
          state_d = LOCK1;
          cnt_d   = CW'(1);
        end
      end
      LOCK0, LOCK1: begin
        cnt_d = cnt_inc;
        if (((state_q == LOCK0) ? !lock0 : !lock1) || (cnt_inc >= CW'(LOCK_MAX))) begin
          lock_err_d = (state_q == LOCK0) ? lock0 : lock1;
          state_d    = IDLE;
          cnt_d      = '0;
          last_d     = (state_q == LOCK1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= 1'b1;
      lock_err_q <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      lock_err_q <= lock_err_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign gnt0     = gnt[0];
  assign gnt1     = gnt[1];
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign lock_err = lock_err_q;
`ifdef DMEM_ARB_ALIGN_CHK_EN
  assign align_err0 = gnt[0] & mis;
  assign align_err1 = gnt[1] & mis;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected grants/reads, a monitor pops and compares.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 0, lock0 = 0, req1 = 0, lock1 = 0;
  logic [2:0]  op0 = 0, op1 = 0;
  logic [31:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
  logic        gnt0, gnt1, rvalid0, rvalid1, lock_err;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_op;
`ifdef DMEM_ARB_ALIGN_CHK_EN
  logic        align_err0, align_err1;
`endif

  dmem_arbiter #(.AW(32), .DW(32), .LOCK_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .op0(op0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .op1(op1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .lock_err(lock_err)
`ifdef DMEM_ARB_ALIGN_CHK_EN
    , .align_err0(align_err0), .align_err1(align_err1)
`endif
  );

  always #5 clk = ~clk;

  // Word memory model: word i initialised to 0xA5000000 | i.
  logic [31:0] mem [0:63];
  initial for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 | i;
  always @(posedge clk) if (rst_n && mem_op == 3'd7) mem[mem_addr[7:2]] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[7:2]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic port; logic [2:0] op; logic [31:0] addr; logic [31:0] wd; logic mis; } gnt_t;
  typedef struct { int c; logic [31:0] d; } rd_t;
  gnt_t gq[$];
  rd_t  rq0[$], rq1[$];
  int   lq[$];
  int   checks = 0, errors = 0;

  task automatic chk(input bit ok, input string nm, input string act, input string req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%s required=%s", nm, act, req);
    end
  endtask

  task automatic setp(input logic r0, input logic [2:0] o0, input logic [31:0] a0, input logic [31:0] w0, input logic l0,
                      input logic r1, input logic [2:0] o1, input logic [31:0] a1, input logic [31:0] w1, input logic l1);
    @(posedge clk); #1;
    req0 = r0; op0 = o0; addr0 = a0; wdata0 = w0; lock0 = l0;
    req1 = r1; op1 = o1; addr1 = a1; wdata1 = w1; lock1 = l1;
  endtask

  task automatic expg(input logic p, input logic [2:0] o, input logic [31:0] a, input logic [31:0] w, input logic m);
    gnt_t e;
    e.c = cyc; e.port = p; e.op = o; e.addr = a; e.wd = w; e.mis = m;
    gq.push_back(e);
  endtask

  task automatic exprd(input logic p, input logic [31:0] d);
    rd_t e;
    e.c = cyc + 1; e.d = d;
    if (p) rq1.push_back(e); else rq0.push_back(e);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (gnt0 || gnt1) begin
        if (gq.size() == 0) chk(1'b0, "gnt_unexpected", $sformatf("cyc%0d g0=%b g1=%b", cyc, gnt0, gnt1), "none");
        else begin
          gnt_t e;
          e = gq.pop_front();
          chk(cyc == e.c && gnt1 == e.port && gnt0 == !e.port && mem_op == e.op && mem_addr == e.addr && mem_wdata == e.wd,
              "gnt", $sformatf("cyc%0d g1=%b g0=%b op%0d a%h w%h", cyc, gnt1, gnt0, mem_op, mem_addr, mem_wdata),
              $sformatf("cyc%0d port%0d op%0d a%h w%h", e.c, e.port, e.op, e.addr, e.wd));
`ifdef DMEM_ARB_ALIGN_CHK_EN
          chk((e.port ? align_err1 : align_err0) == e.mis && !(e.port ? align_err0 : align_err1),
              "align_err", $sformatf("%b%b", align_err1, align_err0), $sformatf("port%0d=%b", e.port, e.mis));
`endif
        end
      end
      if (rvalid0) begin
        if (rq0.size() == 0) chk(1'b0, "rvalid0_unexpected", $sformatf("cyc%0d", cyc), "none");
        else begin
          rd_t e;
          e = rq0.pop_front();
          chk(cyc == e.c && rdata0 == e.d, "rdata0", $sformatf("cyc%0d %h", cyc, rdata0), $sformatf("cyc%0d %h", e.c, e.d));
        end
      end
      if (rvalid1) begin
        if (rq1.size() == 0) chk(1'b0, "rvalid1_unexpected", $sformatf("cyc%0d", cyc), "none");
        else begin
          rd_t e;
          e = rq1.pop_front();
          chk(cyc == e.c && rdata1 == e.d, "rdata1", $sformatf("cyc%0d %h", cyc, rdata1), $sformatf("cyc%0d %h", e.c, e.d));
        end
      end
      if (lock_err) begin
        if (lq.size() == 0) chk(1'b0, "lock_err_unexpected", $sformatf("cyc%0d", cyc), "none");
        else begin
          int e;
          e = lq.pop_front();
          chk(cyc == e, "lock_err", $sformatf("cyc%0d", cyc), $sformatf("cyc%0d", e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #12;
    chk(!gnt0 && !gnt1 && !rvalid0 && !rvalid1 && !lock_err, "reset_flags",
        $sformatf("%b%b%b%b%b", gnt0, gnt1, rvalid0, rvalid1, lock_err), "00000");
    chk(rdata0 == 0 && rdata1 == 0, "reset_rdata", $sformatf("%h %h", rdata0, rdata1), "0 0");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk(mem_op == 3'd0 && mem_addr == 0 && mem_wdata == 0, "idle_drive",
        $sformatf("%0d %h %h", mem_op, mem_addr, mem_wdata), "0 0 0");

    // Store then load on port 0
    setp(1, 3'd7, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0); expg(0, 3'd7, 32'h10, 32'hDEADBEEF, 0);
    setp(1, 3'd0, 32'h10, 32'h0, 0, 0, 0, 0, 0, 0);        expg(0, 3'd0, 32'h10, 32'h0, 0); exprd(0, 32'hDEADBEEF);
    setp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Port 1 alone, then tie alternating 0,1,0,1
    setp(0, 0, 0, 0, 0, 1, 3'd0, 32'h24, 0, 0); expg(1, 3'd0, 32'h24, 0, 0); exprd(1, 32'hA500_0009);
    for (int k = 0; k < 4; k++) begin
      setp(1, 3'd0, 32'h20, 0, 0, 1, 3'd0, 32'h24, 0, 0);
      if (k % 2 == 0) begin expg(0, 3'd0, 32'h20, 0, 0); exprd(0, 32'hA500_0008); end
      else begin expg(1, 3'd0, 32'h24, 0, 0); exprd(1, 32'hA500_0009); end
    end
    setp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Port 1 locks for 3 accesses while port 0 waits
    setp(0, 0, 0, 0, 0, 1, 3'd0, 32'h24, 0, 1);           expg(1, 3'd0, 32'h24, 0, 0); exprd(1, 32'hA500_0009);
    setp(1, 3'd0, 32'h20, 0, 0, 1, 3'd0, 32'h24, 0, 1);   expg(1, 3'd0, 32'h24, 0, 0); exprd(1, 32'hA500_0009);
    setp(1, 3'd0, 32'h20, 0, 0, 1, 3'd0, 32'h24, 0, 1);   expg(1, 3'd0, 32'h24, 0, 0); exprd(1, 32'hA500_0009);
    setp(1, 3'd0, 32'h20, 0, 0, 0, 0, 0, 0, 0);
    setp(1, 3'd0, 32'h20, 0, 0, 0, 0, 0, 0, 0);           expg(0, 3'd0, 32'h20, 0, 0); exprd(0, 32'hA500_0008);
    setp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Port 0 holds lock 10 cycles; forced release after 8 grants
    setp(1, 3'd0, 32'h20, 0, 1, 0, 0, 0, 0, 0);           expg(0, 3'd0, 32'h20, 0, 0); exprd(0, 32'hA500_0008);
    for (int k = 2; k <= 8; k++) begin
      setp(1, 3'd0, 32'h20, 0, 1, 1, 3'd0, 32'h24, 0, 0); expg(0, 3'd0, 32'h20, 0, 0); exprd(0, 32'hA500_0008);
    end
    lq.push_back(cyc + 1);
    setp(1, 3'd0, 32'h20, 0, 1, 1, 3'd0, 32'h24, 0, 0);   expg(1, 3'd0, 32'h24, 0, 0); exprd(1, 32'hA500_0009);
    setp(1, 3'd0, 32'h20, 0, 1, 0, 0, 0, 0, 0);           expg(0, 3'd0, 32'h20, 0, 0); exprd(0, 32'hA500_0008);
    setp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    setp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset between a granted load and its rvalid
    setp(1, 3'd0, 32'h20, 0, 0, 0, 0, 0, 0, 0);           expg(0, 3'd0, 32'h20, 0, 0);
    @(negedge clk); #1;
    rst_n = 1'b0; req0 = 1'b0;
    #1;
    chk(!rvalid0 && rdata0 == 0 && !gnt0, "reset_mid_load",
        $sformatf("rv%b rd%h g%b", rvalid0, rdata0, gnt0), "rv0 rd0 g0");
    @(posedge clk); #1;
    chk(!rvalid0 && rdata0 == 0, "reset_rvalid_dropped", $sformatf("rv%b rd%h", rvalid0, rdata0), "rv0 rd0");
    @(negedge clk); rst_n = 1'b1;
    setp(1, 3'd0, 32'h20, 0, 0, 1, 3'd0, 32'h24, 0, 0);   expg(0, 3'd0, 32'h20, 0, 0); exprd(0, 32'hA500_0008);
    setp(0, 0, 0, 0, 0, 1, 3'd0, 32'h24, 0, 0);           expg(1, 3'd0, 32'h24, 0, 0); exprd(1, 32'hA500_0009);
    setp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

`ifdef DMEM_ARB_ALIGN_CHK_EN
    // Misaligned store suppressed, misaligned load returns zero
    setp(1, 3'd7, 32'h12, 32'h1234_5678, 0, 0, 0, 0, 0, 0); expg(0, 3'd0, 32'h12, 32'h1234_5678, 1);
    setp(1, 3'd0, 32'h10, 0, 0, 0, 0, 0, 0, 0);             expg(0, 3'd0, 32'h10, 0, 0); exprd(0, 32'hDEADBEEF);
    setp(0, 0, 0, 0, 0, 1, 3'd1, 32'h25, 0, 0);             expg(1, 3'd0, 32'h25, 0, 1); exprd(1, 32'h0);
    setp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`endif

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk(gq.size() == 0 && rq0.size() == 0 && rq1.size() == 0 && lq.size() == 0, "pending_expected",
        $sformatf("g%0d r0_%0d r1_%0d l%0d", gq.size(), rq0.size(), rq1.size(), lq.size()), "all 0");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
